// File: rtl/aes_key_sched_ctrl.sv
// ============================================================================
// aes_key_sched_ctrl
// ----------------------------------------------------------------------------
// Iterative AES-128 key-schedule controller. A start request captures the
// cipher key, then ten expansion rounds are sequenced through a shared
// external 4-byte S-box over a req/ack handshake. All 11 round keys are kept
// in a register store and any one of them can be read by index, independent
// of the expansion FSM.
//
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   start       in   single-cycle expand request (ignored while busy)
//   cipher_key  in   [row][col] byte = key byte 4*col+row
//   sbox_req    out  S-box request, high exactly while in SUB
//   sbox_in     out  RotWord of last column of the previous round key
//   sbox_ack    in   S-box result valid (sampled only while sbox_req is high)
//   sbox_out    in   SubWord(sbox_in)
//   key_sel     in   round-key index to read (0..15)
//   busy        out  expansion in progress (LOAD, SUB or XOR)
//   key_rdy     out  all round keys valid
//   round_key   out  registered store[key_sel], zero for key_sel > NUM_ROUNDS
//
// Build option
//   AES_KEY_SCHED_CACHE_EN : when defined, a start in DONE whose cipher_key
//   equals the stored key 0 is accepted but skips re-expansion (the FSM stays
//   in DONE). When undefined, every accepted start re-expands.
//
// NUM_ROUNDS is fixed at 10 (AES-128); other values are not supported.
// ============================================================================
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [3:0][3:0][7:0]  cipher_key,
    output logic                  sbox_req,
    output logic [3:0][7:0]       sbox_in,
    input  logic                  sbox_ack,
    input  logic [3:0][7:0]       sbox_out,
    input  logic [3:0]            key_sel,
    output logic                  busy,
    output logic                  key_rdy,
    output logic [3:0][3:0][7:0]  round_key
);

    typedef logic [3:0][3:0][7:0] key_t;   // [row][col] bytes
    typedef logic [3:0][7:0]      word_t;  // one column, [row] bytes

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SUB  = 3'd2;
    localparam logic [2:0] S_XOR  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0] state_q, state_d;
    logic [3:0] r_q, r_d;              // round currently being produced
    word_t      temp_q, temp_d;        // SubWord result captured on ack
    key_t       store_q [0:NUM_ROUNDS];
    key_t       store_d [0:NUM_ROUNDS];
    key_t       round_key_q, round_key_d;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // ------------------------------------------------------------------------
    // Previous round key (store[r-1]) and the round-key candidate built from it
    // ------------------------------------------------------------------------
    logic [3:0] prev_idx;
    key_t       prev_key;
    key_t       new_key;
    word_t      rot_word;
    logic       cache_hit;
    logic       start_go;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        prev_idx = r_q - 4'd1;
        prev_key = '0;
        // Explicit mux over valid entries: an index outside 0..NUM_ROUNDS
        // (r=0 wraps to 15) simply selects nothing.
        for (int k = 0; k <= NUM_ROUNDS; k++) begin
            if (4'(k) == prev_idx) begin
                prev_key = store_q[k];
            end
        end
    end

    always_comb begin
        rot_word = '0;
        new_key  = '0;
        // RotWord: row i takes row (i+1)%4 of the last column.
        for (int i = 0; i < 4; i++) begin
            rot_word[i] = prev_key[(i + 1) % 4][3];
        end
        // Column 0 mixes in SubWord and rcon (row 0 only); columns 1..3 chain
        // off the freshly computed column to their left within this cycle.
        for (int i = 0; i < 4; i++) begin
            new_key[i][0] = prev_key[i][0] ^ temp_q[i] ^ ((i == 0) ? rcon(r_q) : 8'h00);
        end
        for (int c = 1; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                new_key[i][c] = prev_key[i][c] ^ new_key[i][c - 1];
            end
        end
    end

`ifdef AES_KEY_SCHED_CACHE_EN
    // Restarting with the key already expanded is a no-op.
    assign cache_hit = (state_q == S_DONE) && (cipher_key == store_q[0]);
`else
    assign cache_hit = 1'b0;
`endif

    assign start_go = start && ((state_q == S_IDLE) || (state_q == S_DONE)) && !cache_hit;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        temp_d  = temp_q;
        store_d = store_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_go) begin
                    state_d = S_LOAD;
                    r_d     = 4'd1;
                end
            end

            S_LOAD: begin
                store_d[0] = cipher_key;
                state_d    = S_SUB;
            end

            S_SUB: begin
                if (sbox_ack) begin
                    temp_d  = sbox_out;
                    state_d = S_XOR;
                end
            end

            S_XOR: begin
                for (int k = 1; k <= NUM_ROUNDS; k++) begin
                    if (4'(k) == r_q) begin
                        store_d[k] = new_key;
                    end
                end
                r_d     = r_q + 4'd1;
                state_d = (r_q == LAST_ROUND) ? S_DONE : S_SUB;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Read port: independent of the FSM, zero for indices beyond the store.
    always_comb begin
        round_key_d = '0;
        for (int k = 0; k <= NUM_ROUNDS; k++) begin
            if (4'(k) == key_sel) begin
                round_key_d = store_q[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            temp_q      <= '0;
            round_key_q <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            temp_q      <= temp_d;
            round_key_q <= round_key_d;
        end
    end

    // NOTE: the key store is reset on purpose: reads of keys not yet written
    // must return zero, and a reset must wipe key material.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k <= NUM_ROUNDS; k++) begin
                store_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k <= NUM_ROUNDS; k++) begin
                store_q[k] <= store_d[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sbox_req  = (state_q == S_SUB);
    // Held at zero outside SUB so the bus is quiet when not requesting.
    assign sbox_in   = (state_q == S_SUB) ? rot_word : '0;
    assign busy      = (state_q == S_LOAD) || (state_q == S_SUB) || (state_q == S_XOR);
    assign key_rdy   = (state_q == S_DONE);
    assign round_key = round_key_q;

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller. It captures a cipher key, sequences ten expansion rounds through a shared external 4-byte S-box over a req/ack handshake, and stores all 11 round keys. It then serves any round key by index to the encryption round datapath. It sits between the top-level encrypt control and the key-gen S-box, replacing free-running key generation with an explicit, handshaked schedule.

## Interface
- NUM_ROUNDS, 10: number of expansion rounds; round keys 0..NUM_ROUNDS are stored. Only 10 (AES-128) is supported.
- clk  in  1  clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to expand `cipher_key`.
- cipher_key  in  [7:0][3:0][3:0]  key byte at [row][col] is key byte 4*col+row.
- sbox_req  out  1  S-box request; high exactly while the FSM is in SUB.
- sbox_in  out  [7:0][3:0]  RotWord of the last word of the previous round key; stable while sbox_req is high.
- sbox_ack  in  1  S-box result valid; sampled only while sbox_req is high.
- sbox_out  in  [7:0][3:0]  SubWord(sbox_in); valid when sbox_ack is high.
- key_sel  in  4  round-key index to read.
- busy  out  1  expansion in progress (LOAD, SUB or XOR).
- key_rdy  out  1  all round keys valid.
- round_key  out  [7:0][3:0][3:0]  registered copy of stored key[key_sel].

## Operation
- FSM states: IDLE, LOAD, SUB, XOR, DONE. Reset state is IDLE.
- IDLE or DONE with start=1: go to LOAD, clear key_rdy, set round counter r=1.
- start is ignored while busy.
- LOAD (1 cycle): write cipher_key to store[0], then go to SUB.
- SUB: drive sbox_in[i] = store[r-1][(i+1)%4][3] for rows i=0..3, and assert sbox_req.
  - Stay in SUB until sbox_ack=1.
  - On the ack cycle, latch sbox_out into temp, then go to XOR.
- XOR (1 cycle): compute and write store[r]:
  - col0 = store[r-1] col0 ^ temp ^ {rcon[r],0,0,0}, with rcon applied to row 0 only.
  - colc = store[r-1] colc ^ new col(c-1), for c=1..3, chained within the same cycle.
  - Then r+=1. If the round just written was NUM_ROUNDS, go to DONE and set key_rdy=1; otherwise go to SUB.
- rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. All arithmetic is bytewise XOR with no carries.
- DONE: hold key_rdy=1 until the next accepted start or reset.
- Read port: every cycle, round_key <= store[key_sel] when key_sel <= NUM_ROUNDS, else all zeros.
  - The read is independent of the FSM. Reading a key not yet written returns its current store content, which is zero after reset.
- Reset asserted at any time, including mid-round or with sbox_req high:
  - FSM returns to IDLE; sbox_req, busy and key_rdy go to 0.
  - All store entries, temp, r and round_key clear to 0.
  - A pending ack is discarded.

## Timing
- Reset values: sbox_req=0, sbox_in=0, busy=0, key_rdy=0, round_key=all 0.
- busy is high from the edge after start is sampled through the edge that writes round NUM_ROUNDS; it is low in the same cycle key_rdy rises.
- Round r is written k(r) cycles after the start edge, where k depends on ack latency.
- With sbox_ack tied high:
  - Round r is written at edge 2r+1 after the start-sampling edge (edge 0).
  - key_rdy rises after edge 21.
  - sbox_req is high for exactly 1 cycle per round.
- Each additional ack wait cycle adds 1 cycle to that round.
- sbox_req drops the cycle after the ack is sampled (state is XOR) and never rises in back-to-back cycles.
- round_key read latency: 1 cycle after key_sel changes.

## Configuration
- AES_KEY_SCHED_CACHE_EN defined: a start in DONE whose cipher_key equals store[0] is accepted but skips expansion. The FSM stays in DONE, key_rdy stays 1, busy stays 0, and no sbox_req is issued. A differing key expands normally.
- AES_KEY_SCHED_CACHE_EN undefined: every accepted start re-expands, with key_rdy low for the full expansion.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with sbox_ack tied high -> key_rdy after 21 cycles. key_sel=1 gives a0fafe1788542cb123a339392a6c7605; key_sel=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; key_sel=0 returns the cipher key.
- Same key with a random 0-5 cycle ack delay -> identical keys, sbox_in stable while req is high, exactly 10 req-ack pairs.
- Pulse start again at cycle 5 of the expansion -> ignored; results and timing are identical to scenario 1.
- Assert resetn low while in SUB during round 4 -> the next cycle shows all outputs 0. Reading key_sel=0..10 returns zero; a fresh start expands correctly.
- key_sel=11..15 after DONE -> round_key=0.
- After DONE, restart with the same key:
  - With AES_KEY_SCHED_CACHE_EN: key_rdy never drops and no sbox_req.
  - Without it: key_rdy drops for 21 cycles and keys match.
  - A new key 000102...0f yields round 10 key 13111d7fe3944a17f307a78b4d2b30c5.
